// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
// Provides widths, PC step, the self-loop halt encoding and fetch_entry_t.
package fetch_pkg;

  localparam int PC_W    = 8;
  localparam int INSTR_W = 32;
  localparam int PC_STEP = 4;

  localparam logic [INSTR_W-1:0] HALT_INSTR = 32'h00000063;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetch_entry_t; flush beats push and pop.
// Ports: i_clk, i_rst_n, i_push/i_pop/i_flush, i_data, o_head, o_full, o_empty, o_count.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic          i_flush,
  input  fetch_entry_t  i_data,
  output fetch_entry_t  o_head,
  output logic          o_full,
  output logic          o_empty,
  output logic [CW-1:0] o_count
);

  fetch_entry_t  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end
      if (i_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      r_count <= r_count + CW'(i_push) - CW'(i_pop);
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;

endmodule

// File: rtl/fetch_unit.sv
// Fetch front end: PC register, fetch buffer, redirect flush, optional halt.
// Ports: sysclk, rst_n, curr_pc, instr_in, redirect_valid/redirect_pc,
//   out_valid/out_ready/out_pc/out_instr, halted.
// Option: define FETCH_HALT_DETECT_EN to stop fetching after a beq x0,x0,0.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC   = '0,
  parameter int              FIFO_DEPTH = 2
) (
  input  logic               sysclk,
  input  logic               rst_n,
  output logic [PC_W-1:0]    curr_pc,
  input  logic [INSTR_W-1:0] instr_in,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [PC_W-1:0]    out_pc,
  output logic [INSTR_W-1:0] out_instr,
  output logic               halted
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [PC_W-1:0] r_pc;
  logic            w_push;
  logic            w_pop;
  logic            w_full;
  logic            w_empty;
  logic            w_halted;
  logic [CW-1:0]   w_count;
  fetch_entry_t    w_in;
  fetch_entry_t    w_head;
  logic            w_unused_bits;

  assign w_pop  = out_valid & out_ready;
  assign w_push = !redirect_valid & !w_halted & (!w_full | w_pop);
  assign w_in   = '{pc: r_pc, instr: instr_in};

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (sysclk),
    .i_rst_n (rst_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (redirect_valid),
    .i_data  (w_in),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  always_ff @(posedge sysclk) begin
    if (!rst_n) begin
      r_pc <= RESET_PC;
    end else if (redirect_valid) begin
      r_pc <= {redirect_pc[PC_W-1:2], 2'b00};
    end else if (w_push) begin
      r_pc <= r_pc + PC_W'(PC_STEP);
    end
  end

`ifdef FETCH_HALT_DETECT_EN
  logic r_halted;

  always_ff @(posedge sysclk) begin
    if (!rst_n) begin
      r_halted <= 1'b0;
    end else if (redirect_valid) begin
      r_halted <= 1'b0;
    end else if (w_push && (instr_in == HALT_INSTR)) begin
      r_halted <= 1'b1;
    end
  end

  assign w_halted = r_halted;
`else
  assign w_halted = 1'b0;
`endif

  // Misaligned redirect bits are dropped; count is informational only.
  assign w_unused_bits = ^{redirect_pc[1:0], w_count};

  assign curr_pc   = r_pc;
  assign out_valid = !w_empty;
  assign out_pc    = out_valid ? w_head.pc : '0;
  assign out_instr = out_valid ? w_head.instr : '0;
  assign halted    = w_halted;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed steps plus random traffic
// compared against a queue-based reference model.
module tb_fetch_unit;

`ifdef FETCH_HALT_DETECT_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif

  logic        sysclk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  curr_pc;
  logic [31:0] instr_in;
  logic        redirect_valid = 1'b0;
  logic [7:0]  redirect_pc = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [7:0]  out_pc;
  logic [31:0] out_instr;
  logic        halted;

  logic        rst2_n = 1'b0;
  logic        ready2 = 1'b0;
  logic [7:0]  curr_pc2;
  logic [31:0] instr_in2;
  logic        out_valid2;
  logic [7:0]  out_pc2;
  logic [31:0] out_instr2;
  logic        halted2;

  logic [31:0] mem [64];

  int total = 0;
  int bad = 0;

  always #5 sysclk = ~sysclk;

  assign instr_in  = mem[curr_pc[7:2]];
  assign instr_in2 = mem[curr_pc2[7:2]];

  fetch_unit #(.RESET_PC(8'h00), .FIFO_DEPTH(2)) dut (
    .sysclk         (sysclk),
    .rst_n          (rst_n),
    .curr_pc        (curr_pc),
    .instr_in       (instr_in),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_instr      (out_instr),
    .halted         (halted)
  );

  fetch_unit #(.RESET_PC(8'hFC), .FIFO_DEPTH(2)) dut2 (
    .sysclk         (sysclk),
    .rst_n          (rst2_n),
    .curr_pc        (curr_pc2),
    .instr_in       (instr_in2),
    .redirect_valid (1'b0),
    .redirect_pc    (8'h00),
    .out_valid      (out_valid2),
    .out_ready      (ready2),
    .out_pc         (out_pc2),
    .out_instr      (out_instr2),
    .halted         (halted2)
  );

  typedef struct {
    logic [7:0]  pc;
    logic [31:0] ins;
  } ent_t;

  ent_t       q[$];
  logic [7:0] mpc;
  bit         mh;
  bit         m_init = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s got=%h want=%h", tag, obs, exp_v);
    end
  endtask

  task automatic check_model();
    if (!m_init) return;
    chk("m_curr_pc", {24'd0, curr_pc}, {24'd0, mpc});
    chk("m_out_valid", {31'd0, out_valid}, {31'd0, q.size() > 0});
    if (q.size() > 0) begin
      chk("m_out_pc", {24'd0, out_pc}, {24'd0, q[0].pc});
      chk("m_out_instr", out_instr, q[0].ins);
    end else begin
      chk("m_out_pc_zero", {24'd0, out_pc}, 32'd0);
      chk("m_out_instr_zero", out_instr, 32'd0);
    end
    chk("m_halted", {31'd0, halted}, {31'd0, mh});
  endtask

  task automatic model_edge(input logic r, input logic rdy,
                            input logic rv, input logic [7:0] rp);
    bit   pop;
    bit   push;
    ent_t e;
    if (!r) begin
      q.delete();
      mpc    = 8'h00;
      mh     = 1'b0;
      m_init = 1'b1;
      return;
    end
    if (!m_init) return;
    pop  = (q.size() > 0) && rdy;
    push = !rv && !mh && ((q.size() < 2) || pop);
    e.pc  = mpc;
    e.ins = mem[mpc / 4];
    if (pop) void'(q.pop_front());
    if (rv) begin
      q.delete();
      mpc = rp & 8'hFC;
      mh  = 1'b0;
    end else if (push) begin
      q.push_back(e);
      if (HALT_EN && e.ins == 32'h00000063) mh = 1'b1;
      mpc = mpc + 8'd4;
    end
  endtask

  // Called at a negedge; returns at the following negedge.
  task automatic step(input logic r, input logic rdy,
                      input logic rv, input logic [7:0] rp);
    rst_n          = r;
    out_ready      = rdy;
    redirect_valid = rv;
    redirect_pc    = rp;
    #1;
    check_model();
    @(posedge sysclk);
    model_edge(r, rdy, rv, rp);
    @(negedge sysclk);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin
      mem[i] = $urandom;
      if (mem[i] == 32'h00000063) mem[i] = 32'h00000013;
    end
    mem[0]  = 32'h02a00293;
    mem[1]  = 32'h02100313;
    mem[3]  = 32'h00000063;
    mem[16] = 32'h00000533;
    mem[17] = 32'h00052283;

    @(negedge sysclk);

    // Test 1: reset and free-running fetch
    step(1'b0, 1'b1, 1'b0, 8'h00);
    step(1'b0, 1'b1, 1'b0, 8'h00);
    chk("rst_curr_pc", {24'd0, curr_pc}, 32'h00);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_pc", {24'd0, out_pc}, 32'd0);
    chk("rst_out_instr", out_instr, 32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    step(1'b1, 1'b1, 1'b0, 8'h00);
    chk("t1_pc04", {24'd0, curr_pc}, 32'h04);
    chk("t1_out_pc0", {24'd0, out_pc}, 32'h00);
    chk("t1_out_i0", out_instr, 32'h02a00293);
    step(1'b1, 1'b1, 1'b0, 8'h00);
    chk("t1_pc08", {24'd0, curr_pc}, 32'h08);
    chk("t1_out_pc4", {24'd0, out_pc}, 32'h04);
    chk("t1_out_i4", out_instr, 32'h02100313);
    step(1'b1, 1'b1, 1'b0, 8'h00);
    chk("t1_pc0c", {24'd0, curr_pc}, 32'h0C);

    // Test 2: backpressure from reset
    step(1'b0, 1'b0, 1'b0, 8'h00);
    step(1'b1, 1'b0, 1'b0, 8'h00);
    step(1'b1, 1'b0, 1'b0, 8'h00);
    step(1'b1, 1'b0, 1'b0, 8'h00);
    chk("t2_pc_hold", {24'd0, curr_pc}, 32'h08);
    chk("t2_out_pc", {24'd0, out_pc}, 32'h00);
    chk("t2_out_i", out_instr, 32'h02a00293);
    step(1'b1, 1'b1, 1'b0, 8'h00);
    chk("t2_deliv4", {24'd0, out_pc}, 32'h04);
    step(1'b1, 1'b1, 1'b0, 8'h00);
    chk("t2_deliv8", {24'd0, out_pc}, 32'h08);

    // Test 3: redirect while full
    step(1'b1, 1'b0, 1'b0, 8'h00);
    step(1'b1, 1'b0, 1'b0, 8'h00);
    step(1'b1, 1'b0, 1'b1, 8'h40);
    chk("t3_flush_valid", {31'd0, out_valid}, 32'd0);
    chk("t3_pc40", {24'd0, curr_pc}, 32'h40);
    step(1'b1, 1'b0, 1'b0, 8'h00);
    chk("t3_out_pc", {24'd0, out_pc}, 32'h40);
    chk("t3_out_i", out_instr, 32'h00000533);

    // Test 4: misaligned redirect target
    step(1'b1, 1'b1, 1'b1, 8'h45);
    chk("t4_pc44", {24'd0, curr_pc}, 32'h44);
    step(1'b1, 1'b1, 1'b0, 8'h00);
    chk("t4_out_pc", {24'd0, out_pc}, 32'h44);
    chk("t4_out_i", out_instr, 32'h00052283);

    // Test 5: PC wrap on the RESET_PC=FC instance
    chk("t5_rst_pc", {24'd0, curr_pc2}, 32'hFC);
    chk("t5_rst_valid", {31'd0, out_valid2}, 32'd0);
    rst2_n = 1'b1;
    ready2 = 1'b1;
    step(1'b1, 1'b1, 1'b0, 8'h00);
    chk("t5_wrap_pc", {24'd0, curr_pc2}, 32'h00);
    chk("t5_out_fc", {24'd0, out_pc2}, 32'hFC);
    step(1'b1, 1'b1, 1'b0, 8'h00);
    chk("t5_out_00", {24'd0, out_pc2}, 32'h00);
    chk("t5_out_i00", out_instr2, 32'h02a00293);
    chk("t5_halted", {31'd0, halted2}, 32'd0);

    // Test 6: self-loop halt
    step(1'b0, 1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 8'h00);
    chk("t6_pc10", {24'd0, curr_pc}, 32'h10);
    chk("t6_out_0c", {24'd0, out_pc}, 32'h0C);
    chk("t6_halted", {31'd0, halted}, {31'd0, HALT_EN});
    step(1'b1, 1'b1, 1'b0, 8'h00);
    if (HALT_EN) begin
      chk("t6_drained", {31'd0, out_valid}, 32'd0);
      chk("t6_pc_hold", {24'd0, curr_pc}, 32'h10);
    end else begin
      chk("t6_run_valid", {31'd0, out_valid}, 32'd1);
      chk("t6_run_pc", {24'd0, curr_pc}, 32'h14);
    end
    step(1'b1, 1'b1, 1'b1, 8'h40);
    chk("t6_unhalt", {31'd0, halted}, 32'd0);
    step(1'b1, 1'b1, 1'b0, 8'h00);
    chk("t6_resume", {24'd0, curr_pc}, 32'h44);

    // Test 7: reset with entries buffered
    step(1'b1, 1'b0, 1'b0, 8'h00);
    step(1'b1, 1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b0, 1'b0, 8'h00);
    chk("t7_valid", {31'd0, out_valid}, 32'd0);
    chk("t7_pc", {24'd0, curr_pc}, 32'h00);

    // Random traffic against the model
    for (int i = 0; i < 500; i++) begin
      logic r;
      logic rdy;
      logic rv;
      logic [7:0] rp;
      r   = ($urandom_range(63) != 0);
      rdy = ($urandom_range(3) != 0);
      rv  = ($urandom_range(9) == 0);
      rp  = 8'($urandom);
      step(r, rdy, rv, rp);
    end
    step(1'b1, 1'b1, 1'b0, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
